// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - arbitrated N-channel mux with valid/ready inputs and a registered output stage
module rr_arb_mux #(
    parameter int WIDTH = 3,
    parameter int SIZE  = 3,
    parameter int MODE  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [(2**SIZE)*WIDTH-1:0]   in,
    input  logic [(2**SIZE)-1:0]         in_valid,
    output logic [(2**SIZE)-1:0]         in_ready,
    output logic [WIDTH-1:0]             out,
    output logic [SIZE-1:0]              out_select,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int CHANNELS = 2**SIZE;

    logic [SIZE-1:0]  ptr;
    logic [SIZE-1:0]  grant;
    logic [SIZE-1:0]  idx;
    logic [WIDTH-1:0] grant_data;
    logic             found;
    logic             load;
    logic             transfer;

    assign load = !out_valid || out_ready;

    // Search starts at ptr in round-robin mode and at 0 in fixed-priority mode;
    // the SIZE-bit index wraps naturally past CHANNELS-1.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (MODE == 0) ? ptr + SIZE'(k) : SIZE'(k);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SIZE'(i)) begin
                grant_data = in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = found && load && !reset;

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out        <= '0;
            out_select <= '0;
            ptr        <= '0;
        end else if (transfer) begin
            out_valid  <= 1'b1;
            out        <= grant_data;
            out_select <= grant;
            if (MODE == 0) begin
                ptr <= grant + SIZE'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
